// File: rtl/sevenseg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sevenseg_scan_ctrl
//  Function : Time-multiplexed scan controller for an NDIGITS common-anode
//             7-segment display. Feeds one shared decoder a nibble per digit
//             slot and enables the matching (active-low) anode. The displayed
//             value is double-buffered and only swapped at frame boundaries.
//  Options  : LEADING_ZERO_BLANK_EN - blank leading-zero digits (digit 0 is
//             always lit).
//  Revision : 1.0 - initial release
// ============================================================================
module sevenseg_scan_ctrl #(
    parameter int NDIGITS  = 4,
    parameter int PRESCALE = 1000,
    parameter int GUARD    = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic [4*NDIGITS-1:0]   value,
    output logic [3:0]             data,
    output logic [NDIGITS-1:0]     anode,
    output logic                   pending,
    output logic                   frame_done
);

    localparam int c_CNT_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam int c_IDX_W = $clog2(NDIGITS);

    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(PRESCALE - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(NDIGITS - 1);
    localparam logic [c_CNT_W-1:0] c_GUARD    = c_CNT_W'(GUARD);

    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_IDX_W-1:0]   r_idx;
    logic [4*NDIGITS-1:0] r_shadow;
    logic [4*NDIGITS-1:0] r_disp;

    logic                 w_cnt_wrap;
    logic                 w_boundary;
    logic [c_CNT_W-1:0]   w_cnt_nxt;
    logic [c_IDX_W-1:0]   w_idx_nxt;
    logic [4*NDIGITS-1:0] w_disp_nxt;
    logic [3:0]           w_nib [NDIGITS];
    logic                 w_lit;
    logic [NDIGITS-1:0]   w_anode_nxt;

    assign w_cnt_wrap = (r_cnt == c_CNT_LAST);
    assign w_boundary = w_cnt_wrap && (r_idx == c_IDX_LAST);
    assign w_cnt_nxt  = w_cnt_wrap ? '0 : r_cnt + 1'b1;
    assign w_idx_nxt  = !w_cnt_wrap ? r_idx :
                        ((r_idx == c_IDX_LAST) ? '0 : r_idx + 1'b1);

    // A load on the boundary cycle goes straight to the display buffer;
    // otherwise the boundary promotes a pending shadow value.
    assign w_disp_nxt = !w_boundary ? r_disp :
                        (load ? value : (pending ? r_shadow : r_disp));

    // Outputs are computed from the next state so they line up with
    // (r_idx, r_cnt) without a cycle of lag.
    for (genvar g = 0; g < NDIGITS; g++) begin : g_nib
        assign w_nib[g] = w_disp_nxt[4*g +: 4];
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [NDIGITS-1:0] w_upper_zero;

    // w_upper_zero[i] is set when nibbles i..NDIGITS-1 of the next value are 0.
    always_comb begin
        logic v_acc;
        v_acc        = 1'b1;
        w_upper_zero = '0;
        for (int i = NDIGITS - 1; i >= 0; i--) begin
            v_acc           = v_acc && (w_nib[i] == 4'h0);
            w_upper_zero[i] = v_acc;
        end
    end

    assign w_lit = (w_idx_nxt == '0) || !w_upper_zero[w_idx_nxt];
`else
    assign w_lit = 1'b1;
`endif

    // One-hot-low anode for the next slot; all off during the guard window.
    always_comb begin
        w_anode_nxt = '1;
        if ((w_cnt_nxt >= c_GUARD) && w_lit) begin
            w_anode_nxt[w_idx_nxt] = 1'b0;
        end
    end

    // Scan state, double buffer and registered display outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt      <= '0;
            r_idx      <= '0;
            r_shadow   <= '0;
            r_disp     <= '0;
            pending    <= 1'b0;
            frame_done <= 1'b0;
            data       <= 4'h0;
            anode      <= '1;
        end else begin
            r_cnt      <= w_cnt_nxt;
            r_idx      <= w_idx_nxt;
            r_disp     <= w_disp_nxt;
            if (load) begin
                r_shadow <= value;
            end
            if (load) begin
                pending <= !w_boundary;
            end else if (w_boundary) begin
                pending <= 1'b0;
            end
            frame_done <= w_boundary;
            data       <= w_nib[w_idx_nxt];
            anode      <= w_anode_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sevenseg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sevenseg_scan_ctrl
//  Function : Self-checking bench for sevenseg_scan_ctrl
//             (NDIGITS=4, PRESCALE=4, GUARD=1 -> 16-cycle frame).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sevenseg_scan_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic [15:0] value;
    logic [3:0]  data;
    logic [3:0]  anode;
    logic        pending;
    logic        frame_done;

    int n_vec  = 0;
    int n_fail = 0;
    int pos    = 0;       // frame position of current state: idx*4 + cnt
    bit fresh  = 1'b1;    // no boundary seen yet since reset
    logic [15:0] shown = 16'h0000;

    sevenseg_scan_ctrl #(
        .NDIGITS  (4),
        .PRESCALE (4),
        .GUARD    (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .value      (value),
        .data       (data),
        .anode      (anode),
        .pending    (pending),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] value;
        int          load_pos;
        logic        exp_pend;
    } vec_t;

    vec_t vecs [5];

    task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at pos %0d: got %h, expected %h", name, pos, act, exp);
        end
    endtask

    function automatic logic [3:0] exp_anode(input int p, input logic [15:0] v);
        int idx;
        int cnt;
        idx = p / 4;
        cnt = p % 4;
        if (cnt < 1) return 4'b1111;
`ifdef LEADING_ZERO_BLANK_EN
        if (idx > 0 && (v >> (4 * idx)) == 16'h0) return 4'b1111;
`endif
        return ~(4'b0001 << idx);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        pos = (pos + 1) % 16;
        if (pos == 0) fresh = 1'b0;
    endtask

    task automatic check_cyc(input logic [15:0] s);
        logic [15:0] sh;
        sh = s >> (4 * (pos / 4));
        cmp("data", {12'h0, data}, {12'h0, sh[3:0]});
        cmp("anode", {12'h0, anode}, {12'h0, exp_anode(pos, s)});
        cmp("frame_done", {15'h0, frame_done}, {15'h0, (pos == 0 && !fresh)});
    endtask

    task automatic run_to(input int p, input logic [15:0] s);
        for (int k = 0; k < 16; k++) begin
            if (pos == p) break;
            check_cyc(s);
            tick();
        end
    endtask

    task automatic full_frame(input logic [15:0] s);
        for (int k = 0; k < 16; k++) begin
            check_cyc(s);
            tick();
            if (pos == 0) break;
        end
    endtask

    initial begin
        vecs[0] = '{16'h1234, 6,  1'b1};
        vecs[1] = '{16'h0070, 3,  1'b1};
        vecs[2] = '{16'h0000, 12, 1'b1};
        vecs[3] = '{16'hBEEF, 15, 1'b0};
        vecs[4] = '{16'hCAFE, 0,  1'b1};

        reset = 1'b1;
        load  = 1'b0;
        value = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        pos   = 0;
        fresh = 1'b1;

        // Reset state and first slot
        cmp("rst_anode", {12'h0, anode}, 16'h000F);
        cmp("rst_data", {12'h0, data}, 16'h0000);
        cmp("rst_pending", {15'h0, pending}, 16'h0000);
        cmp("rst_frame_done", {15'h0, frame_done}, 16'h0000);
        tick();
        cmp("slot0_anode", {12'h0, anode}, 16'h000E);
        run_to(5, shown);
        cmp("slot1_anode", {12'h0, anode}, 16'h000D);
        run_to(0, shown);
        cmp("first_frame_done", {15'h0, frame_done}, 16'h0001);
        full_frame(shown);

        // Table: load at a given frame position, new value shown next frame
        foreach (vecs[i]) begin
            run_to(vecs[i].load_pos, shown);
            check_cyc(shown);
            load  = 1'b1;
            value = vecs[i].value;
            tick();
            load  = 1'b0;
            value = 16'h0;
            cmp("pending_after_load", {15'h0, pending}, {15'h0, vecs[i].exp_pend});
            run_to(0, shown);
            shown = vecs[i].value;
            cmp("pending_at_frame", {15'h0, pending}, 16'h0000);
            full_frame(shown);
        end

        // Two loads in one frame: last write wins, first never displayed
        run_to(2, shown);
        load = 1'b1; value = 16'hAAAA;
        tick();
        load = 1'b0; value = 16'h0;
        run_to(9, shown);
        load = 1'b1; value = 16'h5555;
        tick();
        load = 1'b0; value = 16'h0;
        cmp("pending_dbl", {15'h0, pending}, 16'h0001);
        run_to(0, shown);
        shown = 16'h5555;
        full_frame(shown);

        // Reset mid-scan with a pending value
        run_to(5, shown);
        load = 1'b1; value = 16'h1234;
        tick();
        load = 1'b0; value = 16'h0;
        run_to(10, shown);
        cmp("pending_pre_rst", {15'h0, pending}, 16'h0001);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        pos   = 0;
        fresh = 1'b1;
        shown = 16'h0000;
        cmp("midrst_anode", {12'h0, anode}, 16'h000F);
        cmp("midrst_data", {12'h0, data}, 16'h0000);
        cmp("midrst_pending", {15'h0, pending}, 16'h0000);
        cmp("midrst_frame_done", {15'h0, frame_done}, 16'h0000);
        tick();
        cmp("midrst_slot0_anode", {12'h0, anode}, 16'h000E);
        run_to(0, shown);
        full_frame(shown);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
